// File: rtl/if_id_ctrl.sv
// if_id_ctrl: sequences PC and IF/ID enables, NOP bubbles and stalls for hazards, branches, imem waits and HALT
module if_id_ctrl #(
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter int IMEM_TIMEOUT = 64,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic imem_stall,
  input  logic ex_branch_taken,
  input  logic idex_mem_read,
  input  logic [2:0] idex_rd,
  input  logic [2:0] ifid_rs,
  input  logic [2:0] ifid_rt,
  input  logic ifid_uses_rs,
  input  logic ifid_uses_rt,
  input  logic id_halt,
  output logic pc_we,
  output logic ifid_we,
  output logic ifid_nop,
  output logic idex_bubble,
  output logic halted,
  output logic imem_err,
  output logic [CNT_W-1:0] stall_count
);
  localparam int WW = $clog2(IMEM_TIMEOUT + 1);
  typedef enum logic [1:0] {RUN, LU_HOLD, IMEM_WAIT, HALT} state_t;
  state_t state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_inc;
  logic lu_hazard;
  if (IMEM_TIMEOUT < 1 || CNT_W < 1 || $bits(NOP_INSTR) != 16) begin : g_bad_params
    $error("if_id_ctrl: invalid parameters");
  end
  assign lu_hazard = idex_mem_read & ((ifid_uses_rs & (ifid_rs == idex_rd)) | (ifid_uses_rt & (ifid_rt == idex_rd)));
  assign wait_inc = (wait_cnt == WW'(IMEM_TIMEOUT)) ? wait_cnt : wait_cnt + 1'b1;
  assign halted = state == HALT;
  // prioritised Mealy decode: branch flush beats halt, load-use and fetch stalls
  always_comb begin
    pc_we = 1'b1;
    ifid_we = 1'b1;
    ifid_nop = 1'b0;
    idex_bubble = 1'b0;
    state_nxt = RUN;
    if (state == HALT) begin
      pc_we = 1'b0;
      ifid_we = 1'b0;
      state_nxt = HALT;
    end else if (ex_branch_taken) begin
      ifid_nop = 1'b1;
      idex_bubble = 1'b1;
    end else if (state == RUN && id_halt) begin
      pc_we = 1'b0;
      ifid_we = 1'b0;
      state_nxt = HALT;
    end else if (state == RUN && lu_hazard) begin
      pc_we = 1'b0;
      ifid_we = 1'b0;
      idex_bubble = 1'b1;
      state_nxt = LU_HOLD;
    end else if (imem_stall) begin
      pc_we = 1'b0;
      ifid_we = state != LU_HOLD;
      ifid_nop = 1'b1;
      state_nxt = IMEM_WAIT;
    end
  end
  // state, fetch-wait timer, sticky timeout flag and saturating stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      wait_cnt <= '0;
      imem_err <= 1'b0;
      stall_count <= '0;
    end else begin
      state <= state_nxt;
      wait_cnt <= (state_nxt == IMEM_WAIT) ? wait_inc : '0;
      imem_err <= imem_err | (state_nxt == IMEM_WAIT && wait_inc == WW'(IMEM_TIMEOUT));
      stall_count <= stall_count + CNT_W'(!pc_we && state != HALT && state_nxt != HALT && stall_count != '1);
    end
  end
endmodule

// File: doc/if_id_ctrl.md
Name: if_id_ctrl

Overview:
- Pipeline control unit that sequences the PC register and the IF/ID pipeline register.
- Decides each cycle whether the PC advances and whether IF/ID loads, holds, or loads a NOP bubble.
- Sources of control: load-use hazards, taken branches/jumps from EX, instruction-memory stalls, and HALT.
- Sits between fetch, decode and EX; drives the write enables and the NOP-select of the IF/ID flops.

Parameters:
- NOP_INSTR, 16'h0800, encoding the IF/ID register captures when a bubble is inserted.
- IMEM_TIMEOUT, 64, consecutive imem_stall cycles after which imem_err is raised.
- CNT_W, 16, width of stall_count.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
imem_stall  in  1  instruction memory not ready this cycle
ex_branch_taken  in  1  EX resolved a taken branch/jump; PC mux selects target
idex_mem_read  in  1  instruction in ID/EX is a load
idex_rd  in  3  destination register of ID/EX instruction
ifid_rs  in  3  source reg 1 of IF/ID instruction
ifid_rt  in  3  source reg 2 of IF/ID instruction
ifid_uses_rs  in  1  IF/ID instruction reads rs
ifid_uses_rt  in  1  IF/ID instruction reads rt
id_halt  in  1  IF/ID instruction decodes as HALT
pc_we  out  1  PC register load enable
ifid_we  out  1  IF/ID register load enable
ifid_nop  out  1  IF/ID captures NOP_INSTR instead of fetched instruction
idex_bubble  out  1  ID/EX captures a bubble (control signals zeroed)
halted  out  1  pipeline frozen by HALT
imem_err  out  1  sticky: fetch stall exceeded IMEM_TIMEOUT
stall_count  out  CNT_W  cycles with pc_we=0 while not halted, saturating

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- On reset:
  - state=RUN, stall_count=0, imem_err=0, wait counter=0.
  - Outputs: pc_we=1, ifid_we=1, ifid_nop=0, idex_bubble=0, halted=0.
- States: RUN, LU_HOLD, IMEM_WAIT, HALT. Outputs are Mealy (state + current inputs). All state updates occur on the rising edge of clk.
- lu_hazard = idex_mem_read & ((ifid_uses_rs & ifid_rs==idex_rd) | (ifid_uses_rt & ifid_rt==idex_rd)).
- Priority in RUN, LU_HOLD and IMEM_WAIT, highest first:
  1. ex_branch_taken: pc_we=1, ifid_we=1, ifid_nop=1, idex_bubble=1. Next state is RUN; the wait counter clears. Any concurrent hazard, halt or imem_stall is ignored because it belongs to the wrong path.
  2. id_halt (RUN only): pc_we=0, ifid_we=0, idex_bubble=0 (HALT flows on). Next state is HALT.
  3. lu_hazard (RUN only): pc_we=0, ifid_we=0, idex_bubble=1. Next state is LU_HOLD.
  4. imem_stall: pc_we=0, ifid_we=1, ifid_nop=1. Next state is IMEM_WAIT; the wait counter increments.
  5. Otherwise: pc_we=1, ifid_we=1, ifid_nop=0, idex_bubble=0. Next state is RUN.
- LU_HOLD:
  - lu_hazard is ignored, so the hold lasts exactly one cycle.
  - Rules 1, 4 and 5 apply. An imem_stall here uses ifid_we=0, because IF/ID still holds the dependent instruction.
- IMEM_WAIT:
  - While imem_stall: hold as in rule 4 and increment the wait counter.
  - When imem_stall drops: rule 5 applies, the counter clears, and the next state is RUN.
  - Wait counter reaching IMEM_TIMEOUT: set imem_err (sticky until rst). The stall continues.
- HALT:
  - pc_we=0, ifid_we=0, ifid_nop=0, idex_bubble=0, halted=1.
  - Leaves HALT only on rst; all other inputs are ignored.
- stall_count:
  - Increments on each clock where pc_we=0 and state!=HALT and the next state is not HALT.
  - Saturates at all-ones.
- Reset asserted mid-stall or mid-halt returns immediately (asynchronously) to the reset values.

Test Plan:
- Load-use hazard: idex_mem_read=1, idex_rd=3, ifid_rs=3, ifid_uses_rs=1 → cycle 0 pc_we=0, ifid_we=0, idex_bubble=1; cycle 1 (inputs unchanged) pc_we=1, ifid_we=1; stall_count=1.
- Branch plus hazard: ex_branch_taken=1 with lu_hazard=1 and imem_stall=1 → pc_we=1, ifid_nop=1, idex_bubble=1; next state RUN; stall_count unchanged.
- Instruction-memory stall: imem_stall high for 3 cycles → pc_we=0, ifid_nop=1 for 3 cycles, then pc_we=1; stall_count=3; imem_err=0.
- Timeout: IMEM_TIMEOUT=4 and imem_stall held 6 cycles → imem_err=1 after the 4th stall cycle; remains 1 after imem_stall drops; cleared by rst.
- Halt: id_halt=1 → next cycle halted=1, pc_we=0, ifid_we=0. Toggling branch/stall inputs has no effect. rst pulse → halted=0, pc_we=1.
- Halt on wrong path: id_halt=1 and ex_branch_taken=1 in the same cycle → halted stays 0 and IF/ID is loaded with NOP_INSTR 0x0800.
